fp_result_stage: RTL

FP_RESULT_STAGE -- requirements
Module: fp_result_stage

---
 rtl/fp_result_stage_pkg.sv | 44 ++++
 rtl/fp_result_stage_fifo.sv | 64 ++++++
 rtl/fp_result_stage.sv | 73 +++++++
 3 files changed

// File: rtl/fp_result_stage_pkg.sv
// Shared constants, result-entry type and result fix-up function for the
// multiplier result stage.
package fp_result_stage_pkg;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  localparam int ENTRY_W = 35;

  typedef struct packed {
    logic [2:0]  flags;  // {invalid, overflow, underflow}
    logic [31:0] res;
  } entry_t;

  // Special cases are tested in priority order: NaN/invalid, then infinity or
  // overflow, then underflow. A flag is raised only by the case that wins.
  function automatic entry_t fix_up(input logic [31:0] res,
                                    input logic        ovf,
                                    input logic        unf,
                                    input logic        nan,
                                    input logic        inf,
                                    input logic        inv);
    entry_t e;
    e.flags           = '0;
    e.flags[FLAG_INV] = inv;
    if (inv || nan) begin
      e.res = QNAN;
    end else if (inf || ovf) begin
      e.res             = {res[31], EXP_MAX, 23'h0};
      e.flags[FLAG_OVF] = ovf & ~inf;
    end else if (unf) begin
      e.res             = {res[31], 31'h0};
      e.flags[FLAG_UNF] = 1'b1;
    end else begin
      e.res = res;
    end
    return e;
  endfunction

endpackage

// File: rtl/fp_result_stage_fifo.sv
// fp_result_fifo: DEPTH-entry synchronous FIFO with occupancy count; holds the
// fixed-up results until the downstream consumer takes them.
module fp_result_fifo
  import fp_result_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is reset so the head reads as zero out of reset; this keeps
  // the array in flops rather than a RAM macro, acceptable at this depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fp_result_stage.sv
// Multiplier result stage: fixes up special-case results, buffers them with
// per-result exception flags and accumulates sticky flags at push time.
module fp_result_stage
  import fp_result_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_res,
  input  logic        in_ovf,
  input  logic        in_unf,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [2:0]  out_flags,
  input  logic        flags_clr,
  output logic [2:0]  sticky_flags
);

  entry_t     push_entry;
  entry_t     head_entry;
  logic       full, empty;
  logic       push, pop;
  logic [2:0] sticky_q, sticky_d;

  assign push_entry = fix_up(in_res, in_ovf, in_unf, in_nan, in_inf, in_inv);

  // in_ready comes from buffer state only, so a full stage refuses a push
  // even when the head is being popped in the same cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fp_result_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_res   = head_entry.res;
  assign out_flags = head_entry.flags;

  // A clear in the same cycle as a push leaves exactly the pushed flags.
  always_comb begin
    sticky_d = flags_clr ? 3'b000 : sticky_q;
    if (push) sticky_d = sticky_d | push_entry.flags;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;

endmodule
